ahb_sram_slave: RTL and testbench

- Word-organised on-chip SRAM slave that sits on one HADDR_S/HWDATA_S/HRDATA_S port of the 4-slave AHB interconnect, at the address region selected by HADDR[31:30].
- Consumes the address/control the interconnect forwards and returns HRDATA/HREADY/HRESP.
- Supports pipelined address/data phases, configurable wait states, byte/halfword/word access and a two-cycle ERROR response.

---
 rtl/ahb_sram_slave.sv | 88 ++++++++
 tb/tb_ahb_sram_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB word SRAM slave with wait states, two-cycle ERROR and read-after-write forwarding; AHB_SRAM_SEQ_ZERO_WAIT_EN makes error-free SEQ burst beats zero-wait
module ahb_sram_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRST,
    input  logic        HSEL,
    input  logic        HREADYIN,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HPROT,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [DEPTH];
    logic          accept, err, zero_wait, from_wait, commit, fwd, rd_load;
    logic [AW-1:0] rd_idx;
    logic [3:0]    be;
    logic [31:0]   mask, merged;
    logic          unused_ok;
    assign HREADY    = !(state_q inside {WAIT, ERR1});
    assign HRESP     = state_q inside {ERR1, ERR2};
    assign HRDATA    = rdata_q;
    assign unused_ok = ^{HPROT, HBURST, HTRANS[2], HADDR[31:30]};
    always_comb begin
        accept = HSEL && HREADYIN && HTRANS[1] && HREADY;
        err = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) ||
              (HSIZE == 3'd2 && HADDR[1:0] != 2'd0) || HADDR[29:0] >= 30'(DEPTH * 4);
`ifdef AHB_SRAM_SEQ_ZERO_WAIT_EN
        zero_wait = WAIT_STATES == 0 || (HTRANS == 3'd3 && HBURST != 3'd0);
`else
        zero_wait = WAIT_STATES == 0;
`endif
        state_d = accept ? (err ? ERR1 : zero_wait ? DONE : WAIT)
                : state_q == WAIT ? (cnt_q == 3'd0 ? DONE : WAIT)
                : state_q == ERR1 ? ERR2 : IDLE;
        cnt_d   = accept ? 3'(WAIT_STATES - 1)
                : (state_q == WAIT && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
        addr_d  = accept ? HADDR[AW+1:0] : addr_q;
        size_d  = accept ? HSIZE : size_q;
        write_d = accept ? HWRITE : write_q;
        be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0]
           : size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = (mem[addr_q[AW+1:2]] & ~mask) | (HWDATA & mask);
        commit    = state_q == DONE && write_q;
        from_wait = state_q == WAIT;
        rd_idx    = from_wait ? addr_q[AW+1:2] : HADDR[AW+1:2];
        rd_load   = state_d == DONE && (from_wait ? !write_q : !HWRITE);
        // a read loaded on the same edge a write commits sees the merged word
        fwd     = commit && rd_idx == addr_q[AW+1:2];
        rdata_d = rd_load ? (fwd ? merged : mem[rd_idx]) : rdata_q;
    end
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end
    always_ff @(posedge HCLK) begin
        if (!HRST && commit) mem[addr_q[AW+1:2]] <= merged;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized pipelined AHB master against a transaction-level memory model, three wait-state configs
module tb_ahb_sram_slave;
    localparam int N = 3;
    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;
    logic        clk = 1'b0;
    logic        hrst = 1'b1;
    logic        hsel [N];
    logic        hwrite [N];
    logic        hready [N];
    logic        hresp [N];
    logic [31:0] haddr [N];
    logic [31:0] hwdata [N];
    logic [31:0] hrdata [N];
    logic [2:0]  hsize [N];
    logic [2:0]  htrans [N];
    logic [2:0]  hburst [N];
    logic [2:0]  hprot [N];
    logic [31:0] mdl [N][256];
    xfer_t       q[$];
    int          n_chk = 0;
    int          n_err = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) begin : g_dut
        ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 2)) u_dut (
            .HCLK(clk), .HRST(hrst), .HSEL(hsel[g]), .HREADYIN(hready[g]),
            .HADDR(haddr[g]), .HWRITE(hwrite[g]), .HSIZE(hsize[g]), .HTRANS(htrans[g]),
            .HBURST(hburst[g]), .HPROT(hprot[g]), .HWDATA(hwdata[g]),
            .HRDATA(hrdata[g]), .HREADY(hready[g]), .HRESP(hresp[g])
        );
    end
    function automatic int ws(input int k);
        return k == 0 ? 1 : k == 1 ? 0 : 2;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d, input logic [2:0] t, input logic [2:0] b);
        xfer_t x;
        x.sel = 1'b1; x.addr = a; x.wr = w; x.size = s; x.wdata = d; x.trans = t; x.burst = b;
        return x;
    endfunction
    function automatic xfer_t rnd();
        xfer_t x;
        int off;
        x.sel   = $urandom_range(9) != 0;
        x.wr    = 1'($urandom_range(1));
        x.size  = $urandom_range(9) == 0 ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
        x.trans = $urandom_range(9) < 2 ? 3'($urandom_range(1)) : 3'($urandom_range(3, 2));
        x.burst = 3'($urandom_range(7));
        x.wdata = $urandom;
        off = $urandom_range(31) * 4;
        off += $urandom_range(9) == 0 ? $urandom_range(3)
             : x.size == 0 ? $urandom_range(3) : x.size == 1 ? $urandom_range(1) * 2 : 0;
        if ($urandom_range(19) == 0) off += 32'h400 * $urandom_range(3, 1);
        x.addr = {2'($urandom_range(3)), 30'(off)};
        return x;
    endfunction
    task automatic drive_idle(input int k);
        hsel[k] = 1'b0; htrans[k] = 3'd0; haddr[k] = '0; hwrite[k] = 1'b0;
        hsize[k] = 3'd2; hburst[k] = 3'd0;
    endtask
    task automatic drive_addr(input int k, input xfer_t x);
        hsel[k] = x.sel; haddr[k] = x.addr; hwrite[k] = x.wr; hsize[k] = x.size;
        htrans[k] = x.trans; hburst[k] = x.burst; hprot[k] = 3'($urandom_range(7));
    endtask
    task automatic run(input int k);
        xfer_t       c;
        logic        act, err, zw;
        int          lows, exp_lows, idx;
        logic [31:0] w;
        if (q.size() == 0) return;
        drive_addr(k, q[0]);
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            if (i + 1 < q.size()) drive_addr(k, q[i + 1]);
            else drive_idle(k);
            hwdata[k] = c.wdata;
            act = c.sel && c.trans[1];
            err = act && (c.size > 2 || (c.size == 1 && c.addr[0]) ||
                          (c.size == 2 && c.addr[1:0] != 0) || c.addr[29:0] >= 30'h400);
`ifdef AHB_SRAM_SEQ_ZERO_WAIT_EN
            zw = c.trans == 3 && c.burst != 0;
`else
            zw = 1'b0;
`endif
            exp_lows = !act ? 0 : err ? 1 : zw ? 0 : ws(k);
            lows = 0;
            @(negedge clk);
            while (!hready[k] && lows < 20) begin
                chk($sformatf("u%0d resp_wait #%0d", k, i), 32'(hresp[k]), 32'(err));
                lows++;
                @(negedge clk);
            end
            chk($sformatf("u%0d wait_cycles #%0d", k, i), 32'(lows), 32'(exp_lows));
            chk($sformatf("u%0d resp #%0d", k, i), 32'(hresp[k]), 32'(err));
            idx = int'(c.addr[9:2]);
            if (act && !err) begin
                if (c.wr) begin
                    w = mdl[k][idx];
                    for (int b = 0; b < (1 << c.size); b++)
                        w[8 * (int'(c.addr[1:0]) + b) +: 8] = c.wdata[8 * (int'(c.addr[1:0]) + b) +: 8];
                    mdl[k][idx] = w;
                end else begin
                    chk($sformatf("u%0d rdata #%0d @%h", k, i, c.addr), hrdata[k], mdl[k][idx]);
                end
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask
    task automatic abort(input int k);
        drive_addr(k, mk(32'h8, 1'b1, 3'd2, ~mdl[k][2], 3'd2, 3'd0));
        @(posedge clk); #1;
        drive_idle(k);
        hwdata[k] = ~mdl[k][2];
        hrst = 1'b1;
        @(posedge clk); #1;
        hrst = 1'b0;
        @(negedge clk);
        chk($sformatf("u%0d abort hready", k), 32'(hready[k]), 32'd1);
        chk($sformatf("u%0d abort hresp", k), 32'(hresp[k]), 32'd0);
        chk($sformatf("u%0d abort hrdata", k), hrdata[k], 32'd0);
        q.push_back(mk(32'h8, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
        run(k);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        for (int k = 0; k < N; k++) begin
            drive_idle(k);
            hwdata[k] = '0;
            hprot[k] = '0;
        end
        hrst = 1'b1;
        repeat (2) @(posedge clk);
        #1 hrst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d reset hready", k), 32'(hready[k]), 32'd1);
            chk($sformatf("u%0d reset hresp", k), 32'(hresp[k]), 32'd0);
            chk($sformatf("u%0d reset hrdata", k), hrdata[k], 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 32; i++) q.push_back(mk(32'(i * 4), 1'b1, 3'd2, $urandom, 3'd2, 3'd0));
            q.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 3'd2, 3'd0));
            q.push_back(mk(32'h10, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
            q.push_back(mk(32'h20, 1'b1, 3'd2, 32'h1122_3344, 3'd2, 3'd0));
            q.push_back(mk(32'h22, 1'b1, 3'd0, 32'h00AA_0000, 3'd2, 3'd0));
            q.push_back(mk(32'h20, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
            q.push_back(mk(32'h06, 1'b1, 3'd2, 32'hFFFF_FFFF, 3'd2, 3'd0));
            q.push_back(mk(32'h04, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
            q.push_back(mk(32'h400, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
            q.push_back(mk(32'h30, 1'b1, 3'd2, 32'h5555_AAAA, 3'd2, 3'd0));
            q.push_back(mk(32'h30, 1'b0, 3'd2, 32'd0, 3'd2, 3'd0));
            q.push_back(mk(32'h40, 1'b0, 3'd2, 32'd0, 3'd2, 3'd3));
            q.push_back(mk(32'h44, 1'b0, 3'd2, 32'd0, 3'd3, 3'd3));
            q.push_back(mk(32'h48, 1'b0, 3'd2, 32'd0, 3'd3, 3'd3));
            q.push_back(mk(32'h4C, 1'b0, 3'd2, 32'd0, 3'd3, 3'd3));
            run(k);
            abort(k);
            for (int i = 0; i < 150; i++) q.push_back(rnd());
            run(k);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
